// File: rtl/apb_cmd_master_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// apb_cmd_master_if : command/response stream plus APB3 bus bundle
// Revision: 1.0
// ============================================================================
interface apb_cmd_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 2,
  parameter int CMD_DEPTH  = 4
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [ADDR_WIDTH-1:0]         cmd_addr;
  logic [DATA_WIDTH-1:0]         cmd_wdata;
  logic [$clog2(CMD_DEPTH):0]    cmd_level;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic                          rsp_write;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          rsp_timeout;
  logic                          busy;
  logic [ADDR_WIDTH-1:0]         PADDR;
  logic                          PWRITE;
  logic [NUM_SEL-1:0]            PSEL;
  logic                          PENABLE;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic [NUM_SEL*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SEL-1:0]            PREADY;
  logic [NUM_SEL-1:0]            PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, cmd_level, rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout,
           busy, PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, cmd_level, rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout,
           busy, PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// apb_cmd_master : FIFO-buffered command stream to APB3 master with wait
//                  states, slave errors, address decode and timeout
// Revision: 1.0
// ============================================================================
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SEL        = 2,
  parameter int SEL_SHIFT      = 6,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  apb_cmd_master_if.master bus
);
  localparam int c_PTR_W  = $clog2(CMD_DEPTH);
  localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam int c_CMD_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
  localparam logic [c_PTR_W:0]    c_PTR_ONE   = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W:0]    c_FULL_LVL  = (c_PTR_W + 1)'(CMD_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [c_CMD_W-1:0]      mem_q [CMD_DEPTH];
  logic [c_PTR_W:0]        wr_ptr_q, rd_ptr_q, vis_ptr_q;
  logic [c_PTR_W:0]        level;
  logic                    full, avail, push, pop;
  logic                    head_write;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [DATA_WIDTH-1:0]   head_wdata;
  logic [NUM_SEL-1:0]      head_sel;
  logic                    sel_ready, sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [NUM_SEL-1:0]      psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [c_WAIT_W-1:0]     wait_q, wait_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == c_FULL_LVL);
  assign push  = bus.cmd_valid & ~full;
  // vis_ptr lags wr_ptr by one edge so a fresh entry is only poppable a cycle after it lands
  assign avail = (vis_ptr_q != rd_ptr_q);
  assign {head_write, head_addr, head_wdata} = mem_q[rd_ptr_q[c_PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[c_PTR_W-1:0]] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end
  end

  always_comb begin
    head_sel = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      head_sel[i] = ((head_addr >> SEL_SHIFT) == ADDR_WIDTH'(i));
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (psel_q[i]) begin
        sel_ready = sel_ready | bus.PREADY[i];
        sel_err   = sel_err | bus.PSLVERR[i];
        sel_rdata = sel_rdata | bus.PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    wait_d        = wait_q;
    rsp_valid_d   = rsp_valid_q & ~bus.rsp_ready;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (avail && (!rsp_valid_q || bus.rsp_ready)) begin
          pop = 1'b1;
          if (|head_sel) begin
            state_d  = SETUP;
            psel_d   = head_sel;
            paddr_d  = head_addr;
            pwrite_d = head_write;
            pwdata_d = head_wdata;
          end else begin
            rsp_valid_d   = 1'b1;
            rsp_write_d   = head_write;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d       = IDLE;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = pwrite_q;
          rsp_rdata_d   = (!pwrite_q && !sel_err) ? sel_rdata : '0;
          rsp_err_d     = sel_err;
          rsp_timeout_d = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_q == c_WAIT_LAST)) begin
          state_d       = IDLE;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = pwrite_q;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + c_WAIT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      vis_ptr_q     <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      wait_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      vis_ptr_q     <= wr_ptr_q;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      wait_q        <= wait_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = ~full;
  assign bus.cmd_level   = level;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_write   = rsp_write_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.busy        = (state_q != IDLE) | (level != '0) | rsp_valid_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
endmodule
`default_nettype wire
